// File: rtl/mem_slot_scheduler.sv
// rtl/mem_slot_scheduler.sv - four-slot time-division arbiter for the shared RAM/ROM data bus
//
// Purpose:
//   Rotates a fixed four-slot schedule, advancing one slot per cep.
//   Slot 0 goes to video when it is requested, otherwise to the CPU.
//   Slots 1 and 3 always go to the CPU.
//   Slot 2 is shared between sound and the two floppy DMA readers; the CPU gets it when none of them is pending.
//   memAddr, memOE and cpuBusControl are issued on the cep that enters a slot.
//   The owner's data strobe is raised on the cep that ends that slot.
//
// Ports:
//   clk, _reset         system clock, synchronous active-low reset
//   cep                 slot-advance enable
//   videoReq/Addr       video fetch request and address
//   cpuAddr             CPU bus address
//   soundReq/Addr       sound sample fetch request and address
//   dskReqInt/Ext       internal/external floppy read requests
//   dskReadAddrInt/Ext  internal/external floppy read addresses
//   memAddr, memOE      registered memory address and read strobe
//   cpuBusControl       CPU owns the bus this slot
//   videoLatch, loadSound, dskReadAckInt, dskReadAckExt
//                       memoryDataIn holds that requester's data this slot
//   slot                current slot index
module mem_slot_scheduler #(
  parameter int ADDR_W     = 22,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              _reset,
  input  logic              cep,
  input  logic              videoReq,
  input  logic [ADDR_W-1:0] videoAddr,
  input  logic [ADDR_W-1:0] cpuAddr,
  input  logic              soundReq,
  input  logic [ADDR_W-1:0] soundAddr,
  input  logic              dskReqInt,
  input  logic [ADDR_W-1:0] dskReadAddrInt,
  input  logic              dskReqExt,
  input  logic [ADDR_W-1:0] dskReadAddrExt,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memOE,
  output logic              cpuBusControl,
  output logic              videoLatch,
  output logic              loadSound,
  output logic              dskReadAckInt,
  output logic              dskReadAckExt,
  output logic [1:0]        slot
);

  typedef enum logic [2:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_VID,
    OWN_SND,
    OWN_DINT,
    OWN_DEXT
  } owner_t;

  localparam logic       LAST_INT   = 1'b0;
  localparam logic       LAST_EXT   = 1'b1;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  owner_t            owner;
  owner_t            ownerNext;
  logic [1:0]        slotNext;
  logic [ADDR_W-1:0] addrNext;
  logic              oeNext;
  logic              cpuNext;
  logic [3:0]        starve;
  logic [3:0]        starveNext;
  logic              lastDisk;
  logic              lastDiskNext;
  logic              diskPend;
  logic              pickExt;

  always_comb begin
    slotNext     = slot + 2'd1;
    diskPend     = dskReqInt | dskReqExt;
    // With both drives pending, the grant goes to the drive that did not win last time.
    pickExt      = dskReqExt & (~dskReqInt | (lastDisk == LAST_INT));
    ownerNext    = OWN_NONE;
    addrNext     = memAddr;
    oeNext       = 1'b0;
    cpuNext      = 1'b0;
    starveNext   = starve;
    lastDiskNext = lastDisk;

    unique case (slotNext)
      2'd0: ownerNext = videoReq ? OWN_VID : OWN_CPU;
      2'd2: begin
        // Disk wins when sound is idle, or when disk has been starved long enough.
        if (diskPend && ((starve == STARVE_LIM) || !soundReq)) begin
          ownerNext = pickExt ? OWN_DEXT : OWN_DINT;
        end else if (soundReq) begin
          ownerNext = OWN_SND;
        end else begin
          ownerNext = OWN_CPU;
        end
      end
      default: ownerNext = OWN_CPU;
    endcase

    case (ownerNext)
      OWN_CPU: begin
        addrNext = cpuAddr;
        oeNext   = 1'b1;
        cpuNext  = 1'b1;
      end
      OWN_VID: begin
        addrNext = videoAddr;
        oeNext   = 1'b1;
      end
      OWN_SND: begin
        addrNext = soundAddr;
        oeNext   = 1'b1;
      end
      OWN_DINT: begin
        addrNext     = dskReadAddrInt;
        oeNext       = 1'b1;
        lastDiskNext = LAST_INT;
      end
      OWN_DEXT: begin
        addrNext     = dskReadAddrExt;
        oeNext       = 1'b1;
        lastDiskNext = LAST_EXT;
      end
      default: ;
    endcase

    // Count only slot-2 losses to sound while disk is waiting.
    if (slotNext == 2'd2) begin
      if ((ownerNext == OWN_SND) && diskPend) begin
        starveNext = (starve >= STARVE_LIM) ? STARVE_LIM : starve + 4'd1;
      end else begin
        starveNext = 4'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!_reset) begin
      slot          <= 2'd0;
      memAddr       <= '0;
      memOE         <= 1'b0;
      cpuBusControl <= 1'b0;
      videoLatch    <= 1'b0;
      loadSound     <= 1'b0;
      dskReadAckInt <= 1'b0;
      dskReadAckExt <= 1'b0;
      owner         <= OWN_NONE;
      starve        <= 4'd0;
      lastDisk      <= LAST_EXT;
    end else if (cep) begin
      // Strobes report the owner of the slot that is ending.
      videoLatch    <= (owner == OWN_VID);
      loadSound     <= (owner == OWN_SND);
      dskReadAckInt <= (owner == OWN_DINT);
      dskReadAckExt <= (owner == OWN_DEXT);
      slot          <= slotNext;
      owner         <= ownerNext;
      memAddr       <= addrNext;
      memOE         <= oeNext;
      cpuBusControl <= cpuNext;
      starve        <= starveNext;
      lastDisk      <= lastDiskNext;
    end
  end

endmodule
